// File: rtl/hash_block_padder_pkg.sv
// Shared constants, FSM encoding and byte-swap helper for the hash block padder.
package hash_pkg;

  localparam int          BLOCK_WORDS = 16;
  localparam logic [31:0] PAD_MARKER  = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } pad_state_t;

  function automatic logic [31:0] swap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

endpackage

// File: rtl/hash_block_padder_if.sv
// Message request, memory read port and block output of the padder; master is the padder side.
interface hash_block_padder_if #(
  parameter int ADDR_W = 16
);

  logic              start;
  logic [ADDR_W-1:0] message_addr;
  logic [31:0]       size;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [31:0]       mem_read_data;
  logic              blk_valid;
  logic              blk_ready;
  logic [511:0]      blk_data;
  logic              blk_last;
  logic              busy;
  logic              done;

  modport master (
    input  start, message_addr, size, mem_read_data, blk_ready,
    output mem_addr, mem_we, blk_valid, blk_data, blk_last, busy, done
  );

  modport slave (
    output start, message_addr, size, mem_read_data, blk_ready,
    input  mem_addr, mem_we, blk_valid, blk_data, blk_last, busy, done
  );

endinterface

// File: rtl/hash_block_padder_pad_word_gen.sv
// Produces stream word g of the padded message from the captured length and the fetched memory word.
// Purely combinational; no flow control of its own.
module hash_pad_word_gen
  import hash_pkg::*;
(
  input  logic [31:0] g,
  input  logic [31:0] nw,
  input  logic [1:0]  rb,
  input  logic [31:0] nb,
  input  logic [31:0] size,
  input  logic [31:0] mem_read_data,
  output logic [31:0] word
);

  logic [31:0] total_words;
  logic [31:0] swapped;

  assign total_words = 32'(nb * BLOCK_WORDS);
  assign swapped     = swap32(mem_read_data);

  // Length words take priority, then message data, then the marker word.
  always_comb begin
    word = '0;
    if (g == total_words - 32'd1) begin
      word = size << 3;
    end else if (g == total_words - 32'd2) begin
      word = {29'd0, size[31:29]};
    end else if (g < nw) begin
      word = swapped;
    end else if (g == nw) begin
      case (rb)
        2'd0:    word = PAD_MARKER;
        2'd1:    word = (swapped & 32'hFF00_0000) | 32'h0080_0000;
        2'd2:    word = (swapped & 32'hFFFF_0000) | 32'h0000_8000;
        default: word = (swapped & 32'hFFFF_FF00) | 32'h0000_0080;
      endcase
    end
  end

endmodule

// File: rtl/hash_block_padder.sv
// Fetches, byte-swaps and pads a message into 512-bit blocks; block valid 17 edges after start/accept.
// Holds each block (data, last, mem_addr frozen) until blk_ready; one outstanding block at a time.
module hash_block_padder
  import hash_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int BLOCK_WORDS = 16
) (
  input logic                 clk,
  input logic                 reset_n,
  hash_block_padder_if.master bus
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_FILL = FILL;
  localparam logic [1:0] ST_HOLD = HOLD;

  logic [1:0]        state;
  logic [4:0]        slot;
  logic [31:0]       size_q;
  logic [31:0]       nb_q;
  logic [31:0]       blk_cnt;
  logic [31:0]       blk_base;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       buf_q [BLOCK_WORDS];
  logic              last_q;
  logic              done_q;
  logic [31:0]       cap_g;
  logic [3:0]        cap_idx;
  logic [31:0]       gen_word;
  logic [511:0]      blk_flat;

  // Slot k issues word k and captures word k-1, so the captured word trails by one.
  assign cap_g   = blk_base + {27'd0, slot} - 32'd1;
  assign cap_idx = 4'(slot - 5'd1);

  hash_pad_word_gen u_word_gen (
    .g             (cap_g),
    .nw            ({2'b00, size_q[31:2]}),
    .rb            (size_q[1:0]),
    .nb            (nb_q),
    .size          (size_q),
    .mem_read_data (bus.mem_read_data),
    .word          (gen_word)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      slot     <= '0;
      size_q   <= '0;
      nb_q     <= '0;
      blk_cnt  <= '0;
      blk_base <= '0;
      addr_q   <= '0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
      for (int i = 0; i < BLOCK_WORDS; i++) buf_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            size_q   <= bus.size;
            nb_q     <= 32'((({1'b0, bus.size} + 33'd8) >> 6) + 33'd1);
            addr_q   <= bus.message_addr;
            blk_cnt  <= '0;
            blk_base <= '0;
            slot     <= '0;
            state    <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (slot != 5'd0) buf_q[cap_idx] <= gen_word;
          if (slot < 5'd15) addr_q <= addr_q + ADDR_W'(1);
          if (slot == 5'd16) begin
            state  <= ST_HOLD;
            last_q <= (blk_cnt == nb_q - 32'd1);
          end else begin
            slot <= slot + 5'd1;
          end
        end
        ST_HOLD: begin
          if (bus.blk_ready) begin
            last_q <= 1'b0;
            if (last_q) begin
              state  <= ST_IDLE;
              done_q <= 1'b1;
            end else begin
              state    <= ST_FILL;
              slot     <= '0;
              blk_cnt  <= blk_cnt + 32'd1;
              blk_base <= blk_base + 32'd16;
              addr_q   <= addr_q + ADDR_W'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    blk_flat = '0;
    for (int i = 0; i < BLOCK_WORDS; i++) blk_flat[32*(BLOCK_WORDS-1-i) +: 32] = buf_q[i];
  end

  assign bus.mem_addr  = addr_q;
  assign bus.mem_we    = 1'b0;
  assign bus.blk_valid = (state == ST_HOLD);
  assign bus.blk_data  = blk_flat;
  assign bus.blk_last  = last_q;
  assign bus.busy      = (state != ST_IDLE);
  assign bus.done      = done_q;

endmodule

// File: tb/tb_hash_block_padder.sv
// Bench for hash_block_padder: byte-level padding model plus literal pins on directed messages.
module tb_hash_block_padder;

  typedef logic [511:0] blk_t;
  localparam int M_IDLE = 0;
  localparam int M_FILL = 1;
  localparam int M_HOLD = 2;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  hash_block_padder_if #(.ADDR_W(16)) bus ();
  hash_block_padder #(.ADDR_W(16), .BLOCK_WORDS(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] mem [65536];
  logic        rdy_force = 1'b1;
  logic        rdy_val   = 1'b1;

  blk_t        exp_q[$];
  blk_t        acc_dat[$];
  bit          acc_last[$];
  int          mode = M_IDLE;
  int          fill_cnt;
  int          blk_i;
  logic [15:0] m_addr;
  bit          exp_done = 1'b0;

  always @(posedge clk) bus.mem_read_data <= mem[bus.mem_addr];

  always @(posedge clk) begin
    #1;
    bus.blk_ready = rdy_force ? rdy_val : ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] bswap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [31:0] wd(input blk_t b, input int w);
    return b[511-32*w -: 32];
  endfunction

  // Standard MD-style padding over the message bytes, byte j being byte j%4 (LSB first) of memory word j/4.
  function automatic void build_model(input logic [15:0] a, input int unsigned sz);
    byte unsigned b[$];
    logic [31:0]  w;
    logic [63:0]  bits;
    blk_t         blk;
    exp_q.delete();
    for (int unsigned j = 0; j < sz; j++) begin
      w = mem[16'(a + 16'(j / 4))];
      b.push_back(8'(w >> (8 * (j % 4))));
    end
    b.push_back(8'h80);
    while (b.size() % 64 != 56) b.push_back(8'h00);
    bits = 64'(sz) << 3;
    for (int i = 7; i >= 0; i--) b.push_back(8'(bits >> (8 * i)));
    for (int k = 0; k < b.size() / 64; k++) begin
      blk = '0;
      for (int i = 0; i < 64; i++) blk[511-8*i -: 8] = b[64*k+i];
      exp_q.push_back(blk);
    end
  endfunction

  always @(negedge clk) begin
    if (!reset_n) begin
      mode     = M_IDLE;
      exp_done = 1'b0;
      exp_q.delete();
    end else begin
      chk("mem_we", bus.mem_we, 1'b0);
      chk("busy", bus.busy, mode != M_IDLE);
      chk("done", bus.done, exp_done);
      exp_done = 1'b0;
      chk("blk_valid", bus.blk_valid, mode == M_HOLD);
      case (mode)
        M_IDLE: begin
          if (bus.start) begin
            build_model(bus.message_addr, bus.size);
            m_addr   = bus.message_addr;
            blk_i    = 0;
            fill_cnt = 0;
            mode     = M_FILL;
          end
        end
        M_FILL: begin
          if (fill_cnt < 16)
            chk("mem_addr_fill", bus.mem_addr, 16'(m_addr + 16'(16 * blk_i + fill_cnt)));
          fill_cnt++;
          if (fill_cnt == 17) mode = M_HOLD;
        end
        default: begin
          chk("blk_data", bus.blk_data, exp_q[0]);
          chk("blk_last", bus.blk_last, exp_q.size() == 1);
          chk("mem_addr_hold", bus.mem_addr, 16'(m_addr + 16'(16 * blk_i + 15)));
          if (bus.blk_ready) begin
            acc_dat.push_back(bus.blk_data);
            acc_last.push_back(bus.blk_last);
            void'(exp_q.pop_front());
            blk_i++;
            if (exp_q.size() == 0) begin
              mode     = M_IDLE;
              exp_done = 1'b1;
            end else begin
              mode     = M_FILL;
              fill_cnt = 0;
            end
          end
        end
      endcase
    end
  end

  task automatic check_reset(input string nm);
    chk({nm, "_valid"}, bus.blk_valid, 1'b0);
    chk({nm, "_last"}, bus.blk_last, 1'b0);
    chk({nm, "_busy"}, bus.busy, 1'b0);
    chk({nm, "_done"}, bus.done, 1'b0);
    chk({nm, "_we"}, bus.mem_we, 1'b0);
    chk({nm, "_addr"}, bus.mem_addr, 16'h0000);
    chk({nm, "_data"}, bus.blk_data, 512'd0);
  endtask

  task automatic fill_seed(input logic [15:0] a, input logic [31:0] seed, input int n);
    logic [31:0] x;
    x = seed;
    for (int i = 0; i < n; i++) begin
      mem[16'(a + 16'(i))] = x;
      x = {x[30:0], x[31]};
    end
  endtask

  task automatic run_msg(input logic [15:0] a, input logic [31:0] sz, input bit now);
    if (!now) begin
      @(posedge clk);
      #1;
    end
    acc_dat.delete();
    acc_last.delete();
    bus.start        = 1'b1;
    bus.message_addr = a;
    bus.size         = sz;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) seen = 1'b1;
    end
    if (!seen) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: done stayed 0 for 4000 cycles, expected 1", nm);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, expected the run to complete");
    $fatal(1, "time limit");
  end

  initial begin
    bus.start        = 1'b0;
    bus.message_addr = '0;
    bus.size         = '0;
    bus.blk_ready    = 1'b0;
    reset_n          = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = $urandom;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("rst");
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Empty message, then a start in the done cycle.
    run_msg(16'h0100, 32'd0, 1'b0);
    wait_done("t1");
    chk("t1_nblk", acc_dat.size(), 1);
    chk("t1_block", acc_dat[0], {32'h8000_0000, 480'd0});
    chk("t1_last", acc_last[0], 1'b1);
    run_msg(16'h0200, 32'd4, 1'b1);
    wait_done("t1b");
    chk("t1b_nblk", acc_dat.size(), 1);
    chk("t1b_w0", wd(acc_dat[0], 0), bswap(mem[16'h0200]));
    chk("t1b_w1", wd(acc_dat[0], 1), 32'h8000_0000);
    chk("t1b_w15", wd(acc_dat[0], 15), 32'h0000_0020);

    rdy_force = 1'b0;
    fill_seed(16'h1000, 32'h0123_4567, 30);
    run_msg(16'h1000, 32'd120, 1'b0);
    wait_done("t2");
    chk("t2_nblk", acc_dat.size(), 3);
    chk("t2_b0w0", wd(acc_dat[0], 0), 32'h6745_2301);
    chk("t2_b1w14", wd(acc_dat[1], 14), 32'h8000_0000);
    chk("t2_b2w14", wd(acc_dat[2], 14), 32'h0000_0000);
    chk("t2_b2w15", wd(acc_dat[2], 15), 32'h0000_03C0);
    chk("t2_last", {acc_last[0], acc_last[1], acc_last[2]}, 3'b001);

    run_msg(16'h2000, 32'd55, 1'b0);
    wait_done("t3");
    chk("t3_nblk", acc_dat.size(), 1);
    chk("t3_w13", wd(acc_dat[0], 13), (bswap(mem[16'h200D]) & 32'hFFFF_FF00) | 32'h80);
    chk("t3_w14", wd(acc_dat[0], 14), 32'h0);
    chk("t3_w15", wd(acc_dat[0], 15), 32'h0000_01B8);

    run_msg(16'h2100, 32'd56, 1'b0);
    wait_done("t4");
    chk("t4_nblk", acc_dat.size(), 2);
    chk("t4_b0w14", wd(acc_dat[0], 14), 32'h8000_0000);
    chk("t4_b0w15", wd(acc_dat[0], 15), 32'h0);
    chk("t4_b1", acc_dat[1], {480'd0, 32'h0000_01C0});

    // Stalled consumer with a stray start while busy.
    rdy_force = 1'b1;
    rdy_val   = 1'b0;
    run_msg(16'h3000, 32'd10, 1'b0);
    for (int i = 0; i < 100 && !bus.blk_valid; i++) begin
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 10; i++) begin
      bus.start        = (i == 3);
      bus.size         = 32'd200;
      bus.message_addr = 16'h4000;
      chk("t5_valid", bus.blk_valid, 1'b1);
      chk("t5_addr", bus.mem_addr, 16'h300F);
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
    rdy_val   = 1'b1;
    wait_done("t5");
    chk("t5_nblk", acc_dat.size(), 1);

    // Reset in the middle of the second block.
    run_msg(16'h5000, 32'd120, 1'b0);
    for (int i = 0; i < 200 && acc_dat.size() < 1; i++) begin
      @(posedge clk);
      #1;
    end
    repeat (5) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset("t6_rst");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    run_msg(16'h6000, 32'd4, 1'b0);
    wait_done("t6");
    chk("t6_nblk", acc_dat.size(), 1);
    chk("t6_w0", wd(acc_dat[0], 0), bswap(mem[16'h6000]));
    chk("t6_w1", wd(acc_dat[0], 1), 32'h8000_0000);
    chk("t6_w15", wd(acc_dat[0], 15), 32'h0000_0020);
    chk("t6_last", acc_last[0], 1'b1);

    rdy_force = 1'b0;
    for (int r = 0; r < 12; r++) begin
      logic [15:0] a;
      int unsigned sz;
      a  = (r == 0) ? 16'hFFF4 : 16'($urandom);
      sz = $urandom_range(0, 260);
      run_msg(a, sz, 1'b0);
      wait_done("rnd");
      chk("rnd_nblk", acc_dat.size(), (sz + 8) / 64 + 1);
      chk("rnd_last", acc_last[acc_last.size()-1], 1'b1);
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
